// File: rtl/rv32i_core.sv
// rv32i_core: unpipelined RV32I base-integer core, two cycles per instruction.
// The first cycle (FETCH) lets the external synchronous instruction memory
// capture the word at pc; the second (EXECUTE) decodes inst, performs any
// memory access and commits rd and pc on the edge that ends it.
//
// Ports:
//   clk     - system clock, all state changes on the rising edge
//   reset_  - asynchronous active-low reset
//   inst    - instruction word from registered instruction memory
//   pc      - program counter (address of the instruction in flight)
//   addr    - data-memory byte address, rs1+imm for loads/stores in EXECUTE
//   str     - lane-replicated store data, valid in EXECUTE of a store
//   ld      - aligned load word at addr[31:2], read combinationally
module rv32i_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] addr,
    output logic [31:0] str,
    input  logic [31:0] ld
);

    typedef enum logic {FETCH, EXECUTE} state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    state_t      state, state_next;
    logic [31:0] regs [32];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2, shamt;
    logic [2:0]  f3;
    logic [31:0] rs1v, rs2v;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_b, alu_out, mem_addr, store_data, load_data;
    logic [31:0] pc_next, wb_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        wb_en, is_load, is_store, take_branch, alu_legal;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign f3     = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    // x0 is hardwired to zero on read; its storage slot is never written.
    assign rs1v = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2v = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'd0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // State register
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) state <= FETCH;
        else         state <= state_next;
    end

    // Next-state logic: strict alternation between fetch and execute
    always_comb begin
        state_next = FETCH;
        if (state == FETCH) state_next = EXECUTE;
    end

    // Output logic: the data port is only live during EXECUTE of a load/store
    always_comb begin
        addr = 32'd0;
        str  = 32'd0;
        if (state == EXECUTE) begin
            if (is_load || is_store) addr = mem_addr;
            if (is_store)            str  = store_data;
        end
    end

    // Load/store decode; reserved funct3 values fall through as NOPs
    always_comb begin
        is_load    = (opcode == OP_LOAD) && (f3 == 3'b000 || f3 == 3'b001 ||
                     f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101);
        is_store   = (opcode == OP_STORE) && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        mem_addr   = rs1v + ((opcode == OP_STORE) ? imm_s : imm_i);
        store_data = rs2v;
        if (f3 == 3'b000)      store_data = {4{rs2v[7:0]}};
        else if (f3 == 3'b001) store_data = {2{rs2v[15:0]}};
        ld_byte = ld[{mem_addr[1:0], 3'b000} +: 8];
        ld_half = mem_addr[1] ? ld[31:16] : ld[15:0];
        case (f3)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'd0, ld_byte};
            3'b101:  load_data = {16'd0, ld_half};
            default: load_data = ld;
        endcase
    end

    // Shared ALU for register and immediate forms; inst[30] picks SUB/SRA,
    // but SUB only exists in the register form (ADDI has no variant).
    always_comb begin
        alu_b = (opcode == OP_REG) ? rs2v : imm_i;
        shamt = (opcode == OP_REG) ? rs2v[4:0] : inst[24:20];
        case (f3)
            3'b000:  alu_out = (opcode == OP_REG && inst[30]) ? rs1v - alu_b : rs1v + alu_b;
            3'b001:  alu_out = rs1v << shamt;
            3'b010:  alu_out = {31'd0, $signed(rs1v) < $signed(alu_b)};
            3'b011:  alu_out = {31'd0, rs1v < alu_b};
            3'b100:  alu_out = rs1v ^ alu_b;
            3'b101:  alu_out = inst[30] ? 32'($signed(rs1v) >>> shamt) : rs1v >> shamt;
            3'b110:  alu_out = rs1v | alu_b;
            default: alu_out = rs1v & alu_b;
        endcase
        // Only funct7 encodings that RV32I defines are accepted
        if (opcode == OP_REG)
            alu_legal = (inst[31:25] == 7'h00) ||
                        (inst[31:25] == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
        else if (f3 == 3'b001)
            alu_legal = (inst[31:25] == 7'h00);
        else if (f3 == 3'b101)
            alu_legal = (inst[31:25] == 7'h00) || (inst[31:25] == 7'h20);
        else
            alu_legal = 1'b1;
    end

    // Branch condition; funct3 010/011 are reserved and never taken
    always_comb begin
        case (f3)
            3'b000:  take_branch = (rs1v == rs2v);
            3'b001:  take_branch = (rs1v != rs2v);
            3'b100:  take_branch = ($signed(rs1v) <  $signed(rs2v));
            3'b101:  take_branch = ($signed(rs1v) >= $signed(rs2v));
            3'b110:  take_branch = (rs1v <  rs2v);
            3'b111:  take_branch = (rs1v >= rs2v);
            default: take_branch = 1'b0;
        endcase
    end

    // Writeback and next-PC selection; anything unrecognised is a NOP
    always_comb begin
        wb_en   = 1'b0;
        wb_data = 32'd0;
        pc_next = pc + 32'd4;
        case (opcode)
            OP_LUI:   begin wb_en = 1'b1; wb_data = imm_u; end
            OP_AUIPC: begin wb_en = 1'b1; wb_data = pc + imm_u; end
            OP_JAL: begin
                wb_en   = 1'b1;
                wb_data = pc + 32'd4;
                pc_next = pc + imm_j;
            end
            OP_JALR: if (f3 == 3'b000) begin
                wb_en   = 1'b1;
                wb_data = pc + 32'd4;
                pc_next = rs1v + imm_i;
            end
            OP_BRANCH: if (take_branch) pc_next = pc + imm_b;
            OP_LOAD:   if (is_load) begin wb_en = 1'b1; wb_data = load_data; end
            OP_IMM, OP_REG: if (alu_legal) begin wb_en = 1'b1; wb_data = alu_out; end
            default: ;
        endcase
        // No misalignment traps: the low PC bits are simply dropped
        pc_next[1:0] = 2'b00;
    end

    // Architectural commit happens only on the edge that ends EXECUTE
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (state == EXECUTE) begin
            pc <= pc_next;
            if (wb_en && rd != 5'd0) regs[rd] <= wb_data;
        end
    end

endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: directed self-checking bench for rv32i_core. The bench
// plays the instruction memory by presenting each word during FETCH and
// observes register contents by issuing SW xN,0(x0) and reading str.
module tb_rv32i_core;

    logic        clk = 1'b0;
    logic        reset_;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] str;
    logic [31:0] ld;

    int total = 0;
    int bad   = 0;

    logic [31:0] ex_pc, ex_addr, ex_str;

    rv32i_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk    (clk),
        .reset_ (reset_),
        .inst   (inst),
        .pc     (pc),
        .addr   (addr),
        .str    (str),
        .ld     (ld)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Runs one instruction: present it in FETCH, sample the EXECUTE cycle,
    // then return just after the commit edge (back in FETCH).
    task automatic applyStimulus(input logic [31:0] i);
        inst = i;
        @(posedge clk);
        #1;
        ex_pc   = pc;
        ex_addr = addr;
        ex_str  = str;
        @(posedge clk);
        #1;
    endtask

    // Reads register r through SW r,0(x0)
    task automatic checkReg(input string tag, input int r, input logic [31:0] exp);
        applyStimulus(32'h0000_2023 | (32'(r) << 20));
        checkOutput(tag, ex_str, exp);
    endtask

    task automatic doReset();
        reset_ = 1'b0;
        inst   = 32'h0000_0013;
        @(negedge clk);
        checkOutput("reset pc", pc, 32'd0);
        reset_ = 1'b1;
    endtask

    initial begin
        reset_ = 1'b0;
        inst   = 32'd0;
        ld     = 32'd0;
        #12;
        checkOutput("reset addr", addr, 32'd0);
        checkOutput("reset str", str, 32'd0);
        doReset();

        // ADDI x1,x0,5 : pc sequence 0,0,4
        checkOutput("fetch pc", pc, 32'd0);
        applyStimulus(32'h0050_0093);
        checkOutput("exec pc", ex_pc, 32'd0);
        checkOutput("pc after addi", pc, 32'd4);
        checkReg("x1 addi", 1, 32'd5);

        // LW x2,0(x0)
        ld = 32'h0000_000F;
        applyStimulus(32'h0000_2103);
        checkOutput("lw addr", ex_addr, 32'd0);
        checkOutput("lw str", ex_str, 32'd0);
        checkReg("x2 lw", 2, 32'h0000_000F);

        // Byte/half loads with sign and zero extension
        ld = 32'h0000_8000;
        applyStimulus(32'h0010_0183);
        checkOutput("lb addr", ex_addr, 32'd1);
        checkReg("x3 lb", 3, 32'hFFFF_FF80);
        applyStimulus(32'h0010_4183);
        checkReg("x3 lbu", 3, 32'h0000_0080);
        applyStimulus(32'h0000_1183);
        checkReg("x3 lh", 3, 32'hFFFF_8000);

        // Stores: address and replicated data, no register side effects
        applyStimulus(32'h0010_2623);
        checkOutput("sw addr", ex_addr, 32'd12);
        checkOutput("sw str", ex_str, 32'd5);
        applyStimulus(32'h0AB0_0093);
        applyStimulus(32'h0010_01A3);
        checkOutput("sb addr", ex_addr, 32'd3);
        checkOutput("sb str", ex_str, 32'hABAB_ABAB);
        checkReg("x2 after stores", 2, 32'h0000_000F);
        checkReg("x1 after stores", 1, 32'h0000_00AB);

        // Control flow
        doReset();
        applyStimulus(32'h0000_0463);
        checkOutput("beq taken pc", pc, 32'd8);
        doReset();
        applyStimulus(32'h0000_1463);
        checkOutput("bne not taken pc", pc, 32'd4);
        applyStimulus(32'h0100_00EF);
        checkOutput("jal exec pc", ex_pc, 32'd4);
        checkOutput("jal pc", pc, 32'd20);
        checkReg("x1 jal link", 1, 32'd8);
        applyStimulus(32'h0010_8067);
        checkOutput("jalr pc", pc, 32'd8);

        // Arithmetic and edge cases
        applyStimulus(32'h0070_0013);
        checkReg("x0 stays zero", 0, 32'd0);
        applyStimulus(32'h1234_52B7);
        checkReg("x5 lui", 5, 32'h1234_5000);
        applyStimulus(32'h8000_0337);
        applyStimulus(32'h4043_5393);
        checkReg("x7 srai", 7, 32'hF800_0000);
        applyStimulus(32'h0060_3433);
        checkReg("x8 sltu", 8, 32'd1);
        applyStimulus(32'h0003_24B3);
        checkReg("x9 slt neg<0", 9, 32'd1);
        applyStimulus(32'h0060_2533);
        checkReg("x10 slt 0<neg", 10, 32'd0);
        applyStimulus(32'h0072_85B3);
        checkReg("x11 add", 11, 32'h0A34_5000);
        applyStimulus(32'h4050_0633);
        checkReg("x12 sub", 12, 32'hEDCB_B000);

        // Reset asserted in the middle of EXECUTE of ADDI x5,x0,1
        inst = 32'h0010_0293;
        @(posedge clk);
        #1;
        reset_ = 1'b0;
        #1;
        checkOutput("mid-exec reset pc", pc, 32'd0);
        checkOutput("mid-exec reset addr", addr, 32'd0);
        @(negedge clk);
        reset_ = 1'b1;
        checkReg("x5 after reset", 5, 32'd0);
        checkOutput("pc after reset+sw", pc, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32i_core.md
Name: rv32i_core

Overview:
- Unpipelined two-cycle-per-instruction RV32I base-integer core (FETCH, then EXECUTE).
- Instruction memory is external and synchronous: it registers the word at `pc[31:2]` on each rising clock edge and drives it onto `inst`.
- Data memory is external: the core drives `addr` and `str` and reads `ld` combinationally within the same cycle.
- Top-level CPU of the design; no caches, interrupts or privileged state.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into the PC on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_  input  1  asynchronous, active-low reset.
- inst  input  32  instruction word; valid one cycle after `pc` was presented (registered memory).
- pc  output  32  program counter; address of the instruction being fetched/executed.
- addr  output  32  data-memory byte address; rs1+imm during EXECUTE of a load/store, else 0.
- str  output  32  store data, lane-replicated; valid during EXECUTE of a store, else 0.
- ld  input  32  load data: full aligned word at `addr[31:2]`, sampled combinationally in EXECUTE.

Behaviour:
- Reset (reset_=0, asynchronous):
  - pc=RESET_PC; state=FETCH.
  - All 32 registers cleared to 0.
  - addr=0, str=0.
  - Applies mid-instruction too; no register or PC write from the interrupted instruction.
- State machine: FETCH → EXECUTE → FETCH. The state advances only on rising clk edges while reset_=1.
- FETCH:
  - pc held stable; no architectural updates.
  - The memory captures the instruction at the edge ending FETCH.
- EXECUTE:
  - `inst` decoded combinationally.
  - rd written and pc updated on the edge ending EXECUTE.
  - pc_next = pc+4 unless a taken branch or jump occurs.
- Register file: x0 reads 0 always; writes to x0 ignored. Reads are combinational.
- Supported instructions:
  - LUI, AUIPC
  - JAL (rd=pc+4, target pc+immJ)
  - JALR (rd=pc+4, target (rs1+immI)&~1)
  - BEQ/BNE/BLT/BGE/BLTU/BGEU (target pc+immB)
  - LB/LH/LW/LBU/LHU
  - SB/SH/SW
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI
  - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA
- Immediates follow the RV32I I/S/B/U/J encodings and are sign-extended.
- Shift amount: `inst[24:20]` for immediate shifts, rs2[4:0] for register shifts.
- SUB and SRA/SRAI are selected by `inst[30]`.
- All arithmetic is modulo 2^32. SLT/BLT/BGE are signed; SLTU/BLTU/BGEU are unsigned.
- All new PC values have bits [1:0] forced to 0; there are no misalignment traps.
- Loads:
  - Byte lane selected by `addr[1:0]`; halfword by `addr[1]`, from `ld`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes `ld` whole.
- Stores: no write-enable port exists; the environment identifies stores by decoding `inst` during EXECUTE.
  - SW: str=rs2.
  - SH: str={rs2[15:0],rs2[15:0]}.
  - SB: str={4{rs2[7:0]}}.
- FENCE, ECALL, EBREAK, CSR opcodes and any illegal/unknown encoding behave as NOP: pc+=4, no register write.
- Outputs are derived from current state and `inst` only; `ld` affects only the rd write of loads.

Test Plan:
- Reset then `inst`=0x00500093 (ADDI x1,x0,5) → after one FETCH+EXECUTE pair: x1=5, pc=4; `pc` sequence 0,0,4.
- `ld` held 0x0000000F, `inst`=0x00002103 (LW x2,0(x0)) → in EXECUTE addr=0, str=0; after it x2=0x0000000F.
- `ld`=0x00008000, LB x3,1(x0) → x3=0xFFFFFF80; LBU x3,1(x0) → x3=0x00000080; LH x3,0(x0) → x3=0xFFFF8000.
- x1=5, SW x1,12(x0) → EXECUTE: addr=12, str=5. x1=0xAB, SB x1,3(x0) → addr=3, str=0xABABABAB. No register changes in either case.
- BEQ x0,x0,+8 at pc=0 → pc=8. BNE x0,x0,+8 → pc=4. JAL x1,+16 at pc=4 → x1=8, pc=20. JALR x0,x1,1 with x1=8 → pc=8.
- Arithmetic/edge: ADDI x0,x0,7 → x0 stays 0. LUI x5,0x12345 → x5=0x12345000. x6=0x80000000: SRAI x7,x6,4 → 0xF8000000; SLTU x8,x0,x6 → 1; SLT x8,x6,x0 → 1. Assert reset_=0 during EXECUTE → pc=0 immediately, destination register unchanged.
